// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit for the ysyx_22040759 core.
// Owns the PC, issues one word read at a time to the AXI bridge, selects the
// addressed half of the returned 64-bit beat and hands it to decode over a
// valid/ready handshake. Redirects from execute are accepted in every state;
// a read already in flight is drained and its data dropped.
// Optional macro YSYX_22040759_IFU_PERF_EN adds fetch/stall performance counters.
module ysyx_22040759_ifu #(
   parameter int unsigned       ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic              clock,
   input  logic              reset,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [ADDR_W-1:0] if_addr,
   output logic [1:0]        if_size,
   input  logic [63:0]       if_data_read,
   input  logic [1:0]        if_resp,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_fault,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
`ifdef YSYX_22040759_IFU_PERF_EN
  ,output logic [63:0]       perf_fetch_cnt,
   output logic [63:0]       perf_stall_cnt
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
   logic              pc_mis;
   logic [31:0]       fetch_word;

   assign if_size    = 2'b10;
   assign pc_inc     = pc + ADDR_W'(4);
   assign pc_mis     = (pc[1:0] != 2'b00);
   assign fetch_word = pc[2] ? if_data_read[63:32] : if_data_read[31:0];

   // Next state and next PC; a redirect overrides the normal flow in every state.
   // pc+4 keeps the low two bits, so a faulting PC keeps taking the IDLE fault
   // path instead of ever reaching the bus with a misaligned address.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      unique case (state)
         IDLE:    state_nxt = pc_mis ? HOLD : REQ;
         REQ:     if (if_ready) state_nxt = HOLD;
         HOLD: begin
            if (inst_ready) begin
               pc_nxt    = pc_inc;
               state_nxt = pc_mis ? IDLE : REQ;
            end
         end
         DISCARD: if (if_ready) state_nxt = pc_mis ? IDLE : REQ;
         default: state_nxt = IDLE;
      endcase
      if (redirect_valid) begin
         pc_nxt = redirect_pc;
         if ((state == REQ || state == DISCARD) && !if_ready)
            state_nxt = DISCARD;
         else
            state_nxt = (redirect_pc[1:0] != 2'b00) ? IDLE : REQ;
      end
   end

   // State, PC and registered outputs. if_addr only loads on entry to REQ,
   // so it stays on the in-flight address throughout DISCARD.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         if_valid   <= 1'b0;
         if_addr    <= '0;
         inst_valid <= 1'b0;
         inst       <= '0;
         inst_pc    <= '0;
         inst_fault <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         if_valid   <= (state_nxt == REQ) || (state_nxt == DISCARD);
         inst_valid <= (state_nxt == HOLD);
         if (state_nxt == REQ)
            if_addr <= pc_nxt;
         if (state == REQ && if_ready && !redirect_valid) begin
            inst       <= (if_resp != 2'b00) ? NOP : fetch_word;
            inst_pc    <= pc;
            inst_fault <= (if_resp != 2'b00);
         end else if (state == IDLE && pc_mis && !redirect_valid) begin
            inst       <= NOP;
            inst_pc    <= pc;
            inst_fault <= 1'b1;
         end
      end
   end

`ifdef YSYX_22040759_IFU_PERF_EN
   // Delivered-instruction and bus-wait cycle counters, free-running with wrap.
   always_ff @(posedge clock) begin
      if (!reset) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (inst_valid && inst_ready && !redirect_valid)
            perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
         if (state == REQ || state == DISCARD)
            perf_stall_cnt <= perf_stall_cnt + 64'd1;
      end
   end
`endif

endmodule

// File: doc/ysyx_22040759_ifu.md
Name: ysyx_22040759_ifu

Overview:
Instruction fetch unit that sits directly upstream of the AXI bridge (ysyx_22040759_axi) inside the CPU.
- Owns the PC and issues one 32-bit read at a time on the bridge's rw_* request interface (read-only; req is tied to read by the top level).
- Extracts the instruction from the returned 64-bit beat and hands it to decode over a valid/ready handshake.
- Handles redirects from execute, including redirects that arrive while a bus read is in flight.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
ADDR_W, 64, fetch address width.

Ports:
clock  input  1  single clock; all state on rising edge.
reset  input  1  synchronous, active-low reset.
if_valid  output  1  read request to bridge.
if_ready  input  1  bridge completion pulse; if_data_read/if_resp valid this cycle.
if_addr  output  ADDR_W  fetch address (always 4-byte aligned).
if_size  output  2  transfer size; constant 2'b10 (word).
if_data_read  input  64  read data beat.
if_resp  input  2  AXI response; nonzero = error.
inst_valid  output  1  instruction available to decode.
inst_ready  input  1  decode accepts instruction.
inst  output  32  instruction word.
inst_pc  output  ADDR_W  PC of inst.
inst_fault  output  1  fetch error (bus error or misaligned PC); inst = 32'h0000_0013 (NOP) when set.
redirect_valid  input  1  flush and restart fetch.
redirect_pc  input  ADDR_W  new PC.

Behaviour:
Reset (reset==0 at a rising edge):
- pc = RESET_PC, state = IDLE.
- if_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0, inst_fault = 0.
- Reset has priority over everything, including mid-transaction. The top level resets the bridge on the same reset, so no completion pulse is owed.

States:
- IDLE: one cycle after reset, or after a misaligned redirect has been captured; go to REQ. If pc[1:0]!=0, go directly to HOLD instead, with inst_fault=1, inst=NOP, inst_pc=pc, and no bus access.
- REQ:
  - if_valid=1, if_addr=pc, held stable until if_ready.
  - On if_ready: inst = pc[2] ? if_data_read[63:32] : if_data_read[31:0]; inst_pc = pc; inst_fault = (if_resp!=0); go to HOLD.
  - if_valid is decoded from state, so it drops the cycle after if_ready.
- HOLD:
  - inst_valid=1; outputs stable until handshake.
  - On inst_valid & inst_ready: pc = pc+4, go to REQ. Fetch restarts the next cycle, so there are 0 bubble cycles of request gap beyond the bridge latency.
- DISCARD:
  - Entered when a redirect arrives in REQ and the in-flight read cannot be aborted.
  - if_valid stays 1 with if_addr unchanged until if_ready.
  - Returned data is dropped; go to REQ with the new pc.

Redirect (redirect_valid=1):
- pc = redirect_pc in any state.
- REQ without if_ready in the same cycle: go to DISCARD.
- REQ with if_ready in the same cycle: the data is dropped; go to REQ at the new pc.
- DISCARD: stay until if_ready.
- HOLD: inst_valid drops the next cycle, even if inst_ready was high (redirect wins; the instruction is flushed); go to REQ.
- If redirect_pc[1:0]!=0: go to IDLE-fault path; pc captured as given.

Arithmetic and throughput:
- pc+4 wraps modulo 2^ADDR_W.
- Throughput: one instruction per (bridge latency + 1) cycles minimum.

Optional Feature:
Macro YSYX_22040759_IFU_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[63:0] and perf_stall_cnt[63:0], both reset to 0.
  - perf_fetch_cnt increments on each inst_valid & inst_ready handshake with no redirect.
  - perf_stall_cnt increments on each cycle in REQ or DISCARD.
  - Both wrap at 2^64.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, bridge returns 64'h0000_0093_0000_0013 after 3 cycles, inst_ready=1 -> if_addr=0x8000_0000, if_size=2'b10; inst=32'h0000_0013, inst_pc=0x8000_0000; next if_addr=0x8000_0004.
- Fetch at 0x8000_0004, same data -> inst=32'h0000_0093 (upper half selected by pc[2]).
- inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, no new if_valid, pc unchanged.
- Redirect to 0x8000_0100 one cycle after REQ entry, bridge completes 2 cycles later -> that data is never presented (inst_valid stays 0); the next request has if_addr=0x8000_0100.
- Redirect in the same cycle as an inst_valid/inst_ready handshake -> pc=redirect_pc (not +4); the next request is at redirect_pc.
- if_resp=2'b10 on completion -> inst_fault=1, inst=0x0000_0013. Redirect to 0x8000_0102 -> inst_fault=1 with no if_valid asserted.
